hline_cmd_sched: RTL and testbench
==================================

// Module: hline_cmd_sched
// PURPOSE
//  Queues software-prepared horizontal-line commands and sequences the hline z-buffer engine (fsm) one line at a time.
//  Holds each command's parameters stable at the engine inputs, pulses start, and tracks completion via engine curr_state.
//  Sits between the AXI-lite slave register file (producer) and the engine; raises a per-line interrupt and status counters.
// PARAMETERS
//  DEPTH        4    command FIFO entries; power of 2, >=2
//  LAUNCH_TMO   64   cycles start may stay high without the engine leaving IDLE before the command is dropped
// PORTS
//  clk            in   1    clock
//  nreset         in   1    asynchronous active-low reset
//  cmd_valid      in   1    producer has a command
//  cmd_ready      out  1    FIFO not full; push when cmd_valid&&cmd_ready
//  cmd_fb_addr    in   32   framebuffer line base address
//  cmd_zbuff_addr in   32   z-buffer line base address
//  cmd_dx         in   32   line length (sw precomputed)
//  cmd_slope      in   32   integer z step per pixel
//  cmd_z1         in   32   starting z
//  cmd_rem        in   32   fractional remainder of slope
//  cmd_err        in   32   initial error term
//  eng_start      out  1    to engine start
//  eng_fb_addr..eng_err out 32 each  head-entry fields, same order as cmd_*; drive engine inputs
//  eng_state      in   3    engine curr_state (0 = IDLE)
//  sw_clear       in   1    clears lines_done and tmo_err
//  busy           out  1    FIFO non-empty or sequencer not in S_IDLE
//  level          out  $clog2(DEPTH)+1  FIFO occupancy
//  lines_done     out  16   completed/skipped line count, wraps 0xFFFF->0
//  tmo_err        out  1    sticky: a command was dropped on launch timeout
//  irq            out  1    one-cycle pulse per retired command
// BEHAVIOUR
//  Reset (async, any state): FIFO emptied, state S_IDLE; eng_start, irq, tmo_err, busy=0; lines_done=0; level=0; cmd_ready=1.
//  FIFO: push on cmd_valid&&cmd_ready; pop only on retire. cmd_ready=!full, so push while full is impossible.
//   Push and pop in same cycle allowed; level unchanged. Pointers wrap mod DEPTH.
//  eng_* = head entry fields, combinational from FIFO storage; constant from S_IDLE exit until pop.
//  States:
//   S_IDLE:   FIFO non-empty && eng_state==0 -> head dx==0 ? S_RETIRE : S_LAUNCH. Non-empty with eng_state!=0 -> wait.
//   S_LAUNCH: eng_start=1 (registered, asserted from first cycle in state). eng_state!=0 -> S_RUN, eng_start=0 next cycle.
//             tmo counter reaches LAUNCH_TMO-1 while eng_state==0 -> set tmo_err, S_RETIRE without lines_done increment.
//   S_RUN:    eng_start=0. wait eng_state==0 -> S_RETIRE. No timeout (engine cannot be aborted; bus stalls are legal).
//   S_RETIRE: pop head; irq=1 for this one cycle; lines_done+1 (except timeout drop) -> S_IDLE.
//  Latency: push into empty FIFO with idle engine -> eng_start high 2 cycles later (1 FIFO write, 1 S_IDLE decision).
//  Back-to-back: S_RETIRE->S_IDLE->S_LAUNCH; minimum 2 idle-engine cycles between lines.
//  dx==0: never launches the engine; retires in 2 cycles with irq and lines_done increment.
//  sw_clear: synchronous; clears lines_done and tmo_err; if coincident with increment/timeout, clear wins.
//  busy = (level!=0) || (state!=S_IDLE).
//  Reset mid-line: sequencer and FIFO drop all commands; engine shares nreset and returns to IDLE itself.
// TESTING
//  Single line dx=300, engine model leaves IDLE 1 cycle after start, returns after 900 -> one start, one irq, lines_done=1, busy low after.
//  Push 5 commands with DEPTH=4, engine stalled -> cmd_ready low after 4th push, 5th accepted only after first retire; order preserved.
//  Command dx=0 between two dx=256 lines -> engine sees exactly 2 starts; 3 irq pulses; lines_done=3.
//  Engine model never leaves IDLE -> start high exactly 64 cycles, tmo_err=1, entry popped, lines_done unchanged, next command launches.
//  eng_* fields checked constant during S_RUN while 3 further pushes occur; sw_clear same cycle as retire -> lines_done=0, tmo_err=0.
//  Assert nreset in S_RUN with level=3 -> next cycle level=0, eng_start=0, irq=0, busy=0, cmd_ready=1.

Source files
------------

// File: rtl/hline_cmd_sched.sv
// Command FIFO plus sequencer feeding the hline z-buffer engine one line at a time.
// Holds the head command at the engine inputs, pulses start, retires on engine return to IDLE.
module hline_cmd_sched #(
    parameter int DEPTH      = 4,
    parameter int LAUNCH_TMO = 64
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [31:0]              cmd_fb_addr,
    input  logic [31:0]              cmd_zbuff_addr,
    input  logic [31:0]              cmd_dx,
    input  logic [31:0]              cmd_slope,
    input  logic [31:0]              cmd_z1,
    input  logic [31:0]              cmd_rem,
    input  logic [31:0]              cmd_err,
    output logic                     eng_start,
    output logic [31:0]              eng_fb_addr,
    output logic [31:0]              eng_zbuff_addr,
    output logic [31:0]              eng_dx,
    output logic [31:0]              eng_slope,
    output logic [31:0]              eng_z1,
    output logic [31:0]              eng_rem,
    output logic [31:0]              eng_err,
    input  logic [2:0]               eng_state,
    input  logic                     sw_clear,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              lines_done,
    output logic                     tmo_err,
    output logic                     irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = (LAUNCH_TMO > 1) ? $clog2(LAUNCH_TMO) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(LAUNCH_TMO - 1);
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [31:0] fb;
        logic [31:0] zb;
        logic [31:0] dx;
        logic [31:0] slope;
        logic [31:0] z1;
        logic [31:0] rem;
        logic [31:0] err;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_RETIRE
    } state_t;

    cmd_t            mem_q [DEPTH];
    cmd_t            cmd_in;
    cmd_t            head;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    state_t          state_q, state_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic            drop_q;
    logic            eng_start_q;
    logic [15:0]     lines_q, lines_d;
    logic            tmo_err_q, tmo_err_d;
    logic            tmo_hit;
    logic            push, pop;

    assign cmd_in = '{fb: cmd_fb_addr, zb: cmd_zbuff_addr, dx: cmd_dx, slope: cmd_slope,
                      z1: cmd_z1, rem: cmd_rem, err: cmd_err};

    assign cmd_ready = (count_q != FULL_LVL);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == S_RETIRE);

    // Storage needs no reset: emptiness is carried entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= cmd_in;
    end

    assign head           = mem_q[rd_ptr_q];
    assign eng_fb_addr    = head.fb;
    assign eng_zbuff_addr = head.zb;
    assign eng_dx         = head.dx;
    assign eng_slope      = head.slope;
    assign eng_z1         = head.z1;
    assign eng_rem        = head.rem;
    assign eng_err        = head.err;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        tmo_hit   = 1'b0;
        tmo_cnt_d = (state_q == S_LAUNCH) ? tmo_cnt_q + TW'(1) : '0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0 && eng_state == 3'd0)
                    state_d = (head.dx == 32'd0) ? S_RETIRE : S_LAUNCH;
            end
            S_LAUNCH: begin
                // Engine acceptance takes priority over a coincident timeout.
                if (eng_state != 3'd0) begin
                    state_d = S_RUN;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = S_RETIRE;
                    tmo_hit = 1'b1;
                end
            end
            S_RUN: begin
                if (eng_state == 3'd0) state_d = S_RETIRE;
            end
            S_RETIRE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        lines_d   = lines_q;
        tmo_err_d = tmo_err_q;
        if (state_q == S_RETIRE && !drop_q) lines_d = lines_q + 16'd1;
        if (tmo_hit) tmo_err_d = 1'b1;
        if (sw_clear) begin
            lines_d   = '0;
            tmo_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= S_IDLE;
            tmo_cnt_q   <= '0;
            drop_q      <= 1'b0;
            eng_start_q <= 1'b0;
            lines_q     <= '0;
            tmo_err_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            tmo_cnt_q   <= tmo_cnt_d;
            // Only a timeout can lead into the retire cycle with tmo_hit set the cycle before.
            drop_q      <= tmo_hit;
            eng_start_q <= (state_d == S_LAUNCH);
            lines_q     <= lines_d;
            tmo_err_q   <= tmo_err_d;
        end
    end

    assign eng_start  = eng_start_q;
    assign irq        = (state_q == S_RETIRE);
    assign busy       = (count_q != '0) || (state_q != S_IDLE);
    assign level      = count_q;
    assign lines_done = lines_q;
    assign tmo_err    = tmo_err_q;

endmodule

// File: tb/tb_hline_cmd_sched.sv
// Bench for hline_cmd_sched: engine model, command scoreboard, vector table and corner sequences.
module tb_hline_cmd_sched;

    logic        clk = 1'b0;
    logic        nreset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_fb_addr = '0, cmd_zbuff_addr = '0, cmd_dx = '0, cmd_slope = '0;
    logic [31:0] cmd_z1 = '0, cmd_rem = '0, cmd_err = '0;
    logic        eng_start;
    logic [31:0] eng_fb_addr, eng_zbuff_addr, eng_dx, eng_slope, eng_z1, eng_rem, eng_err;
    logic [2:0]  eng_state = 3'd0;
    logic        sw_clear = 1'b0;
    logic        busy;
    logic [2:0]  level;
    logic [15:0] lines_done;
    logic        tmo_err;
    logic        irq;

    always #5 clk = ~clk;

    hline_cmd_sched #(.DEPTH(4), .LAUNCH_TMO(64)) dut (
        .clk(clk), .nreset(nreset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_fb_addr(cmd_fb_addr), .cmd_zbuff_addr(cmd_zbuff_addr), .cmd_dx(cmd_dx),
        .cmd_slope(cmd_slope), .cmd_z1(cmd_z1), .cmd_rem(cmd_rem), .cmd_err(cmd_err),
        .eng_start(eng_start), .eng_fb_addr(eng_fb_addr), .eng_zbuff_addr(eng_zbuff_addr),
        .eng_dx(eng_dx), .eng_slope(eng_slope), .eng_z1(eng_z1), .eng_rem(eng_rem),
        .eng_err(eng_err), .eng_state(eng_state), .sw_clear(sw_clear), .busy(busy),
        .level(level), .lines_done(lines_done), .tmo_err(tmo_err), .irq(irq)
    );

    typedef struct packed {
        logic [31:0] fb;
        logic [31:0] zb;
        logic [31:0] dx;
        logic [31:0] slope;
        logic [31:0] z1;
        logic [31:0] rem;
        logic [31:0] err;
    } cmd_t;

    typedef struct {
        logic [31:0] dx;
        int          run;
        bit          never;
        int          e_starts;
        int          e_irqs;
        int          e_hi;
        int          e_inc;
        bit          e_tmo;
    } vec_t;

    cmd_t sb[$];
    int   n_cmp = 0, n_bad = 0;
    int   starts = 0, irqs = 0, start_hi = 0;
    bit   start_prev = 1'b0;
    int   run_len = 10;
    bit   never_leave = 1'b0;
    int   run_cnt = 0;
    cmd_t cap;
    bit   fld_bad = 1'b0;
    bit   e_done = 1'b0;
    int   exp_lines = 0;

    function automatic cmd_t cur_eng();
        cmd_t c;
        c = {eng_fb_addr, eng_zbuff_addr, eng_dx, eng_slope, eng_z1, eng_rem, eng_err};
        return c;
    endfunction

    function automatic cmd_t mk(input logic [31:0] dx);
        cmd_t c;
        c.fb = $urandom; c.zb = $urandom; c.dx = dx; c.slope = $urandom;
        c.z1 = $urandom; c.rem = $urandom; c.err = $urandom;
        return c;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Engine model plus launch/retire scoreboard checks, all on the falling edge.
    always @(negedge clk) begin
        if (!nreset) begin
            eng_state  = 3'd0;
            run_cnt    = 0;
            start_prev = 1'b0;
        end else begin
            if (eng_start) start_hi++;
            if (eng_start && !start_prev) begin
                starts++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL launch_fields: got start with empty scoreboard");
                end else if (cur_eng() !== sb[0]) begin
                    n_bad++;
                    $display("FAIL launch_fields: got %h expected %h", cur_eng(), sb[0]);
                end
            end
            start_prev = eng_start;
            if (irq) begin
                irqs++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL retire_fields: got irq with empty scoreboard");
                end else begin
                    if (cur_eng() !== sb[0]) begin
                        n_bad++;
                        $display("FAIL retire_fields: got %h expected %h", cur_eng(), sb[0]);
                    end
                    void'(sb.pop_front());
                end
            end
            if (eng_state == 3'd0) begin
                if (eng_start && !never_leave) begin
                    eng_state = 3'd5;
                    run_cnt   = run_len;
                    cap       = cur_eng();
                end
            end else begin
                if (cur_eng() !== cap) fld_bad = 1'b1;
                if (run_cnt <= 1) eng_state = 3'd0;
                else run_cnt--;
            end
        end
    end

    task automatic push_cmd(input cmd_t c);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        {cmd_fb_addr, cmd_zbuff_addr, cmd_dx, cmd_slope, cmd_z1, cmd_rem, cmd_err} = c;
        cmd_valid = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            sb.push_back(c);
        end
        #1 cmd_valid = 1'b0;
        chk("push_accept", ok, 1);
    endtask

    task automatic wait_idle(input int lim, input string nm);
        int i;
        for (i = 0; i < lim; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk(nm, i < lim, 1);
    endtask

    task automatic wait_run(input int lim);
        int i;
        for (i = 0; i < lim; i++) begin
            @(negedge clk);
            if (eng_state != 3'd0) break;
        end
        chk("eng_run_timeout", i < lim, 1);
    endtask

    task automatic wait_irq(input int lim);
        int i;
        for (i = 0; i < lim; i++) begin
            @(negedge clk);
            if (irq) break;
        end
        chk("irq_timeout", i < lim, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no summary within time limit expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[6];
        int   s0, i0, h0;
        vt[0] = '{32'd300,        900, 1'b0, 1, 1, 1,  1, 1'b0};
        vt[1] = '{32'd0,            5, 1'b0, 0, 1, 0,  1, 1'b0};
        vt[2] = '{32'd1,            1, 1'b0, 1, 1, 1,  1, 1'b0};
        vt[3] = '{32'd7,            5, 1'b1, 1, 1, 64, 0, 1'b1};
        vt[4] = '{32'd20,          30, 1'b0, 1, 1, 1,  1, 1'b1};
        vt[5] = '{32'hFFFF_FFFF,    2, 1'b0, 1, 1, 1,  1, 1'b1};

        #2 nreset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_eng_start", eng_start, 0);
        chk("rst_irq", irq, 0);
        chk("rst_tmo_err", tmo_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_lines", lines_done, 0);
        chk("rst_level", level, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        nreset = 1'b1;
        repeat (2) @(negedge clk);

        // Push-to-start latency into an empty FIFO with an idle engine.
        run_len = 3;
        push_cmd(mk(32'd12));
        @(negedge clk);
        chk("lat_cycle1_start", eng_start, 0);
        @(negedge clk);
        chk("lat_cycle2_start", eng_start, 1);
        wait_idle(200, "lat_idle_timeout");
        exp_lines++;
        chk("lat_lines", lines_done, exp_lines);

        for (int v = 0; v < 6; v++) begin
            run_len     = vt[v].run;
            never_leave = vt[v].never;
            s0 = starts; i0 = irqs; h0 = start_hi;
            push_cmd(mk(vt[v].dx));
            wait_idle(3000, "vec_idle_timeout");
            exp_lines += vt[v].e_inc;
            chk($sformatf("vec%0d_starts", v), starts - s0, vt[v].e_starts);
            chk($sformatf("vec%0d_irqs", v), irqs - i0, vt[v].e_irqs);
            chk($sformatf("vec%0d_start_hi", v), start_hi - h0, vt[v].e_hi);
            chk($sformatf("vec%0d_lines", v), lines_done, exp_lines);
            chk($sformatf("vec%0d_tmo_err", v), tmo_err, vt[v].e_tmo);
            chk($sformatf("vec%0d_ready", v), cmd_ready, 1);
        end
        never_leave = 1'b0;

        // Full FIFO: fifth command held off until the first retire.
        run_len = 300;
        i0 = irqs;
        for (int k = 0; k < 4; k++) push_cmd(mk(32'd100 + 32'(k)));
        @(negedge clk);
        chk("full_cmd_ready", cmd_ready, 0);
        chk("full_level", level, 4);
        e_done = 1'b0;
        fork
            begin
                push_cmd(mk(32'd555));
                e_done = 1'b1;
            end
        join_none
        wait_irq(1000);
        chk("full_fifth_blocked", e_done, 0);
        for (int k = 0; k < 20 && !e_done; k++) @(negedge clk);
        chk("full_fifth_accepted", e_done, 1);
        @(negedge clk);
        chk("full_level_refill", level, 4);
        wait_idle(4000, "full_idle_timeout");
        exp_lines += 5;
        chk("full_irqs", irqs - i0, 5);
        chk("full_lines", lines_done, exp_lines);
        chk("full_sb_empty", sb.size(), 0);

        // Zero-length line between two real lines.
        run_len = 20;
        s0 = starts; i0 = irqs;
        push_cmd(mk(32'd256));
        push_cmd(mk(32'd0));
        push_cmd(mk(32'd256));
        wait_idle(500, "dx0_idle_timeout");
        exp_lines += 3;
        chk("dx0_starts", starts - s0, 2);
        chk("dx0_irqs", irqs - i0, 3);
        chk("dx0_lines", lines_done, exp_lines);

        // Engine inputs must hold while further commands are queued.
        run_len = 100;
        fld_bad = 1'b0;
        push_cmd(mk(32'd64));
        wait_run(50);
        for (int k = 0; k < 3; k++) push_cmd(mk(32'd32 + 32'(k)));
        chk("hold_level", level, 4);
        wait_idle(1000, "hold_idle_timeout");
        exp_lines += 4;
        chk("hold_fields_stable", fld_bad, 0);
        chk("hold_lines", lines_done, exp_lines);

        // sw_clear coincident with a retire increment: clear wins.
        run_len = 10;
        chk("pre_clear_tmo", tmo_err, 1);
        push_cmd(mk(32'd9));
        wait_irq(200);
        sw_clear = 1'b1;
        @(negedge clk);
        sw_clear = 1'b0;
        exp_lines = 0;
        chk("clear_lines", lines_done, 0);
        chk("clear_tmo", tmo_err, 0);
        wait_idle(100, "clear_idle_timeout");

        // Reset in S_RUN with three commands queued.
        run_len = 500;
        push_cmd(mk(32'd400));
        wait_run(50);
        push_cmd(mk(32'd401));
        push_cmd(mk(32'd402));
        @(negedge clk);
        chk("prerst_level", level, 3);
        chk("prerst_busy", busy, 1);
        nreset = 1'b0;
        #1;
        chk("midrst_level", level, 0);
        chk("midrst_eng_start", eng_start, 0);
        chk("midrst_irq", irq, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        sb.delete();
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        run_len = 4;
        push_cmd(mk(32'd77));
        wait_idle(100, "post_rst_idle_timeout");
        chk("post_rst_lines", lines_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
